// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arbiter_pkg;

    // Arbiter mode: free round-robin or held by one locked owner.
    typedef enum logic {
        ARB_IDLE_RR = 1'b0,
        ARB_LOCKED  = 1'b1
    } arb_state_e;

    // Width of a requester id; a single requester still gets one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr.
module rr_pick
    import dmem_arbiter_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = id_width(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] winner,
    output logic           any
);

    int             s;
    logic [IDW-1:0] idx;

    // Scan ptr, ptr+1, ... (mod N) and keep the first hit.
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        s      = 0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            idx = s[IDW-1:0];
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin data-memory arbiter with locked (atomic) ownership and
// a 1-cycle read-response return path.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int CORES      = 1,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CORES-1:0]            req_valid,
    output logic [CORES-1:0]            req_ready,
    input  logic [CORES-1:0]            req_we,
    input  logic [CORES-1:0]            req_lock,
    input  logic [CORES*ADDR_WIDTH-1:0] req_addr,
    input  logic [CORES*DATA_WIDTH-1:0] req_wdata,
    output logic [CORES-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic                        lock_timeout
);

    localparam int IDW = id_width(CORES);
    localparam int CW  = $clog2(LOCK_MAX);

    typedef logic [IDW-1:0] core_id_t;

    arb_state_e         state, state_nxt;
    core_id_t           ptr, ptr_nxt;
    core_id_t           owner, owner_nxt;
    logic [CW-1:0]      lock_cnt, lock_cnt_nxt;
    logic               rsp_pend;
    core_id_t           rsp_id;

    logic [CORES-1:0]   pick_grant;
    core_id_t           pick_win;
    logic               pick_any;

    core_id_t           win;
    logic               xfer;

    // Successor id with wrap at CORES-1.
    function automatic core_id_t next_id(input core_id_t id);
        if (int'(id) == CORES - 1) return '0;
        return core_id_t'(id + 1'b1);
    endfunction

    rr_pick #(.N(CORES), .IDW(IDW)) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .grant  (pick_grant),
        .winner (pick_win),
        .any    (pick_any)
    );

    // Grant: round-robin in ARB, owner only while locked.
    always_comb begin
        req_ready = '0;
        win       = pick_win;
        xfer      = 1'b0;
        if (state == ARB_IDLE_RR) begin
            req_ready = pick_grant;
            xfer      = pick_any;
        end else begin
            win            = owner;
            xfer           = req_valid[owner];
            req_ready[owner] = req_valid[owner];
        end
    end

    // Memory side is a zero-latency mux of the winner.
    always_comb begin
        mem_en    = xfer;
        mem_we    = xfer & req_we[win];
        mem_addr  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next state for mode, pointer, owner and lock counter.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        lock_timeout = 1'b0;
        case (state)
            ARB_IDLE_RR: begin
                if (xfer) begin
                    ptr_nxt = next_id(win);
                    if (req_lock[win]) begin
                        state_nxt    = ARB_LOCKED;
                        owner_nxt    = win;
                        lock_cnt_nxt = '0;
                    end
                end
            end
            ARB_LOCKED: begin
                lock_cnt_nxt = CW'(lock_cnt + 1'b1);
                // Timeout wins over a relock; any same-cycle owner transfer
                // has already been granted above.
                if (lock_cnt == CW'(LOCK_MAX - 1)) begin
                    lock_timeout = 1'b1;
                    state_nxt    = ARB_IDLE_RR;
                    ptr_nxt      = next_id(owner);
                    lock_cnt_nxt = '0;
                end else if (xfer && !req_lock[owner]) begin
                    state_nxt    = ARB_IDLE_RR;
                    ptr_nxt      = next_id(owner);
                    lock_cnt_nxt = '0;
                end
            end
            default: state_nxt = ARB_IDLE_RR;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB_IDLE_RR;
            ptr      <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Remember who issued a read so the data returns to them next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend <= 1'b0;
            rsp_id   <= '0;
        end else begin
            rsp_pend <= xfer & ~req_we[win];
            rsp_id   <= win;
        end
    end

    // One-hot response valid, shared data bus.
    always_comb begin
        rsp_valid = '0;
        if (rsp_pend) rsp_valid[rsp_id] = 1'b1;
        rsp_rdata = mem_rdata;
    end

endmodule
